sim_run_ctrl: RTL and testbench
===============================

Name: sim_run_ctrl

Overview:
- Parametrised simulation run controller, instantiated beside the pipeline top in the testbench.
- Stretches the bench reset into a core reset of programmable length.
- Counts cycles and retired instructions.
- Detects end of test from a tohost store, a cycle timeout, or a retire-stall hang, and reports a sticky one-hot verdict.
- Replaces fixed-delay reset and fixed-time finish with cycle-accurate, data-driven termination.

Parameters:
- RST_CYCLES, 4: cycles core_rst stays high after rst falls.
- TIMEOUT_CYCLES, 1000: RUN cycles before a TIMEOUT verdict.
- STALL_LIMIT, 64: consecutive RUN cycles with no retire before a HANG verdict; 0 disables the check.
- ADDR_W, 32: store address width.
- DATA_W, 32: store data width.
- TOHOST_ADDR, 32'h0000_1000: magic tohost address.
- CNT_W, 32: width of the cycle and retire counters.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  data-memory store strobe from the core.
- wr_addr  in  ADDR_W  store address.
- wr_data  in  DATA_W  store data.
- retire_valid  in  1  one instruction retired this cycle.
- core_rst  out  1  stretched reset driven to the pipeline top.
- state  out  3  encoded FSM state (sim_run_ctrl_pkg::state_t).
- done  out  1  terminal verdict reached.
- pass  out  1  tohost reported pass.
- fail  out  1  tohost reported failure.
- timeout  out  1  cycle budget exhausted.
- hang  out  1  retire stall detected.
- fail_code  out  DATA_W-1  wr_data>>1 of the failing tohost store.
- cycle_count  out  CNT_W  RUN cycles elapsed.
- retire_count  out  CNT_W  retires counted in RUN.

Behaviour:
- All outputs are registered. Reset is synchronous: rst sampled high at a clk edge forces, at that edge:
  - state=HOLD, core_rst=1;
  - done, pass, fail, timeout, hang = 0;
  - fail_code, cycle_count, retire_count, the hold counter and the idle counter = 0.
- rst asserted in any state, including mid-RUN or terminal, fully reinitialises the block on that edge.
- HOLD:
  - Hold counter increments each cycle rst is low.
  - When it reaches RST_CYCLES, state goes to RUN and core_rst goes to 0 at the same edge.
  - RST_CYCLES=0: RUN is entered at the first edge with rst low.
  - Inputs are ignored in HOLD.
- RUN:
  - cycle_count increments every cycle.
  - retire_count increments when retire_valid=1.
  - Idle counter clears on retire_valid=1 and increments otherwise.
  - Both counters saturate at all-ones and do not wrap.
- Tohost store condition: wr_en=1 and wr_addr==TOHOST_ADDR.
  - wr_data==1 -> PASS.
  - wr_data[0]==1 and wr_data!=1 -> FAIL, with fail_code=wr_data>>1.
  - wr_data[0]==0 -> ignored, no state change.
  - Stores to any other address are ignored.
- Timeout: in RUN, when cycle_count==TIMEOUT_CYCLES-1 and no higher-priority event occurs, the next edge enters TIMEOUT.
- Hang: in RUN with STALL_LIMIT!=0, when the idle counter reaches STALL_LIMIT-1 and retire_valid=0, the next edge enters HANG.
- Same-cycle priority: tohost verdict > TIMEOUT > HANG. A retire in the deadline cycle is still counted.
- Terminal states PASS, FAIL, TIMEOUT and HANG are sticky until rst.
  - done=1 together with exactly one of pass/fail/timeout/hang, all updated on the transition edge.
  - Counters and fail_code freeze; further stores and retires are ignored.
  - core_rst stays 0.
- Terminal latency: a verdict-triggering input at edge N appears on the outputs after edge N.

Optional Feature:
- Macro SIM_RUN_CTRL_TRACE_EN.
- Defined:
  - a simulation-only block $displays every tohost store (time, data);
  - on entering a terminal state it $displays the verdict, cycle_count, retire_count and fail_code;
  - it then calls $finish two cycles later.
- Undefined: no $display/$finish code is compiled, and the block is purely synthesizable-style RTL whose ports and timing are identical to the defined build.

Decomposition:
- Package sim_run_ctrl_pkg holds:
  - state_t enum {HOLD, RUN, PASS, FAIL, TIMEOUT, HANG}, 3 bits;
  - the TOHOST_PASS value 1.
- Sub-module sim_sat_counter (parametrised width, synchronous clear, enable, saturate at all-ones), instantiated for cycle_count, retire_count and the idle counter.

Test Plan:
- Reset stretch: rst high 3 cycles then low, RST_CYCLES=4 -> core_rst=1 for exactly 4 edges after rst falls, state=RUN at the 4th, cycle_count starts at 0.
- Pass: retire every cycle, store wr_addr=0x1000 wr_data=1 on RUN cycle 20 -> done=1, pass=1, cycle_count frozen at 21, retire_count=21.
- Fail: store wr_data=0x0000_0007 to 0x1000 -> fail=1, fail_code=3. Store of 0x4 earlier -> no effect. Store of 1 to 0x1004 -> no effect.
- Timeout: TIMEOUT_CYCLES=50, retire every cycle, no tohost -> timeout=1 after 50 RUN cycles. A pass store in cycle 49 instead yields pass=1, timeout=0.
- Hang: STALL_LIMIT=8, retire stops after cycle 10 -> hang=1 after 8 idle cycles. Repeat with STALL_LIMIT=0 -> ends in timeout.
- Mid-run reset: assert rst for 1 cycle in RUN at cycle 30, and again in PASS -> all outputs return to reset values at that edge, core_rst restretched, and a subsequent pass store is detected normally.

Source files
------------

// File: rtl/sim_run_ctrl_pkg.sv
// Shared types and constants for the simulation run controller.
package sim_run_ctrl_pkg;

  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    RUN     = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4,
    HANG    = 3'd5
  } state_t;

  // tohost value that signals a passing test; other odd values encode a failure code.
  localparam int unsigned TOHOST_PASS = 1;

  function automatic logic is_terminal(input state_t s);
    return (s == PASS) || (s == FAIL) || (s == TIMEOUT) || (s == HANG);
  endfunction

endpackage

// File: rtl/sim_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones instead of wrapping.
module sim_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sim_run_ctrl.sv
// Simulation run controller: stretches reset, counts cycles/retires, reports a sticky verdict.
// Define SIM_RUN_CTRL_TRACE_EN to print tohost stores and the verdict, then finish the run.
module sim_run_ctrl
  import sim_run_ctrl_pkg::*;
#(
  parameter int unsigned       RST_CYCLES     = 4,
  parameter int unsigned       TIMEOUT_CYCLES = 1000,
  parameter int unsigned       STALL_LIMIT    = 64,
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(32'h0000_1000),
  parameter int                CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              retire_valid,
  output logic              core_rst,
  output state_t            state,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic              hang,
  output logic [DATA_W-2:0] fail_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retire_count
);

  localparam logic [31:0]      HOLD_LAST  = 32'(RST_CYCLES) - 32'd1;
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_LIMIT - 1);

  state_t           state_next;
  logic [31:0]      hold_cnt;
  logic [CNT_W-1:0] idle_cnt;
  logic             run;
  logic             tohost;
  logic             tohost_pass;
  logic             tohost_fail;

  // wr_en and retire_valid are single-cycle strobes with no backpressure: each
  // cycle they are high counts as exactly one store or one retire.
  assign run         = (state == RUN);
  assign tohost      = wr_en && (wr_addr == TOHOST_ADDR);
  assign tohost_pass = tohost && (wr_data == DATA_W'(TOHOST_PASS));
  assign tohost_fail = tohost && wr_data[0] && !tohost_pass;

  sim_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (run),
    .count (cycle_count)
  );

  sim_sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (run && retire_valid),
    .count (retire_count)
  );

  sim_sat_counter #(.W(CNT_W)) u_idle_cnt (
    .clk   (clk),
    .clr   (rst || (run && retire_valid)),
    .en    (run && !retire_valid),
    .count (idle_cnt)
  );

  // Verdict priority within one cycle: tohost, then timeout, then hang.
  always_comb begin
    state_next = state;
    unique case (state)
      HOLD: begin
        if ((RST_CYCLES == 0) || (hold_cnt == HOLD_LAST)) state_next = RUN;
      end
      RUN: begin
        if (tohost_pass)                     state_next = PASS;
        else if (tohost_fail)                state_next = FAIL;
        else if (cycle_count == TO_LAST)     state_next = TIMEOUT;
        else if ((STALL_LIMIT != 0) && !retire_valid && (idle_cnt == STALL_LAST))
                                             state_next = HANG;
      end
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      core_rst  <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      hang      <= 1'b0;
      fail_code <= '0;
    end else begin
      state    <= state_next;
      if (state == HOLD) hold_cnt <= hold_cnt + 32'd1;
      core_rst <= (state_next == HOLD);
      done     <= is_terminal(state_next);
      pass     <= (state_next == PASS);
      fail     <= (state_next == FAIL);
      timeout  <= (state_next == TIMEOUT);
      hang     <= (state_next == HANG);
      if (run && (state_next == FAIL)) fail_code <= wr_data[DATA_W-1:1];
    end
  end

`ifdef SIM_RUN_CTRL_TRACE_EN
  logic [1:0] finish_dly;

  always_ff @(posedge clk) begin
    if (tohost) $display("%0t sim_run_ctrl: tohost store data=%0h", $time, wr_data);
    if (rst) begin
      finish_dly <= '0;
    end else if (done) begin
      if (finish_dly == 2'd0)
        $display("%0t sim_run_ctrl: verdict=%s cycles=%0d retires=%0d fail_code=%0h",
                 $time, state.name(), cycle_count, retire_count, fail_code);
      if (finish_dly == 2'd2) $finish;
      else finish_dly <= finish_dly + 2'd1;
    end
  end
`else
  // Default build carries no trace or run-termination code.
`endif

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: two instances (hang check on / off) share stimulus; verdicts scoreboarded.
module tb_sim_run_ctrl;
  import sim_run_ctrl_pkg::*;

  localparam int          RST_CYC = 4;
  localparam int          TO_CYC  = 50;
  localparam int          STALL_A = 8;
  localparam int          NCYC    = 54;
  localparam int          RW      = 102;
  localparam logic [31:0] TOHOST  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        retire_valid = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  logic        core_rst_a, done_a, pass_a, fail_a, timeout_a, hang_a;
  logic        core_rst_b, done_b, pass_b, fail_b, timeout_b, hang_b;
  state_t      state_a, state_b;
  logic [30:0] fail_code_a, fail_code_b;
  logic [31:0] cycle_count_a, retire_count_a, cycle_count_b, retire_count_b;

  int n_checks = 0;
  int n_err = 0;

  logic [RW-1:0] exp_qa[$];
  logic [RW-1:0] exp_qb[$];
  logic [RW-1:0] last_a = '0, last_b = '0;
  logic [RW-1:0] act_a, act_b;
  logic          prev_a = 1'b0, prev_b = 1'b0;

  bit          s_ret[NCYC];
  bit          s_en[NCYC];
  logic [31:0] s_addr[NCYC];
  logic [31:0] s_data[NCYC];

  sim_run_ctrl #(.RST_CYCLES(RST_CYC), .TIMEOUT_CYCLES(TO_CYC), .STALL_LIMIT(STALL_A),
                 .ADDR_W(32), .DATA_W(32), .TOHOST_ADDR(TOHOST), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .retire_valid(retire_valid), .core_rst(core_rst_a), .state(state_a), .done(done_a),
    .pass(pass_a), .fail(fail_a), .timeout(timeout_a), .hang(hang_a),
    .fail_code(fail_code_a), .cycle_count(cycle_count_a), .retire_count(retire_count_a)
  );

  sim_run_ctrl #(.RST_CYCLES(RST_CYC), .TIMEOUT_CYCLES(TO_CYC), .STALL_LIMIT(0),
                 .ADDR_W(32), .DATA_W(32), .TOHOST_ADDR(TOHOST), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .retire_valid(retire_valid), .core_rst(core_rst_b), .state(state_b), .done(done_b),
    .pass(pass_b), .fail(fail_b), .timeout(timeout_b), .hang(hang_b),
    .fail_code(fail_code_b), .cycle_count(cycle_count_b), .retire_count(retire_count_b)
  );

  // Clock and packed observation vectors
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] pack(input logic [3:0] v, input logic [2:0] st,
                                          input logic [31:0] cyc, input logic [31:0] ret,
                                          input logic [30:0] fc);
    return {v, st, cyc, ret, fc};
  endfunction

  assign act_a = pack({pass_a, fail_a, timeout_a, hang_a}, state_a, cycle_count_a, retire_count_a, fail_code_a);
  assign act_b = pack({pass_b, fail_b, timeout_b, hang_b}, state_b, cycle_count_b, retire_count_b, fail_code_b);

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: walk the RUN-cycle stimulus list and find the first verdict.
  function automatic logic [RW-1:0] model(input int stall, input int n, output bit hit);
    int ret;
    int idle;
    ret = 0;
    idle = 0;
    hit = 1'b0;
    for (int k = 0; k < n; k++) begin
      bit th;
      th = s_en[k] && (s_addr[k] == TOHOST);
      ret += int'(s_ret[k]);
      idle = s_ret[k] ? 0 : idle + 1;
      hit = 1'b1;
      if (th && s_data[k] == 32'd1) return pack(4'b1000, PASS, 32'(k + 1), 32'(ret), '0);
      if (th && s_data[k][0])       return pack(4'b0100, FAIL, 32'(k + 1), 32'(ret), s_data[k][31:1]);
      if (k + 1 == TO_CYC)          return pack(4'b0010, TIMEOUT, 32'(k + 1), 32'(ret), '0);
      if (stall != 0 && idle == stall) return pack(4'b0001, HANG, 32'(k + 1), 32'(ret), '0);
      hit = 1'b0;
    end
    return '0;
  endfunction

  // Monitor: pop an expected verdict when done rises, then require the outputs to stay frozen.
  always @(negedge clk) begin
    if (done_a && !prev_a) begin
      if (exp_qa.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL unexpected_verdict_a: got done=1 state=%0d, want no verdict", state_a);
      end else begin
        last_a = exp_qa.pop_front();
        check("verdict_a", act_a, last_a);
      end
    end else if (done_a) begin
      check("frozen_a", act_a, last_a);
    end
    prev_a = done_a;
    if (done_b && !prev_b) begin
      if (exp_qb.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL unexpected_verdict_b: got done=1 state=%0d, want no verdict", state_b);
      end else begin
        last_b = exp_qb.pop_front();
        check("verdict_b", act_b, last_b);
      end
    end else if (done_b) begin
      check("frozen_b", act_b, last_b);
    end
    prev_b = done_b;
  end

  // Driver tasks
  task automatic junk();
    retire_valid = 1'($urandom_range(0, 1));
    wr_en        = 1'($urandom_range(0, 1));
    wr_addr      = ($urandom_range(0, 1) != 0) ? TOHOST : 32'($urandom);
    wr_data      = ($urandom_range(0, 1) != 0) ? 32'd1 : 32'($urandom);
  endtask

  task automatic apply_reset(input int n);
    state_t exp_st;
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      junk();
      @(posedge clk); #1;
    end
    check("reset_a", act_a, pack(4'b0, HOLD, '0, '0, '0));
    check("reset_b", act_b, pack(4'b0, HOLD, '0, '0, '0));
    check("reset_flags_a", RW'({core_rst_a, done_a}), RW'(2'b10));
    check("reset_flags_b", RW'({core_rst_b, done_b}), RW'(2'b10));
    rst = 1'b0;
    for (int j = 1; j <= RST_CYC; j++) begin
      junk();
      @(posedge clk); #1;
      exp_st = (j < RST_CYC) ? HOLD : RUN;
      check("hold_a", RW'({core_rst_a, state_a, cycle_count_a, retire_count_a}),
            RW'({(j < RST_CYC), exp_st, 64'd0}));
      check("hold_b", RW'({core_rst_b, state_b, cycle_count_b, retire_count_b}),
            RW'({(j < RST_CYC), exp_st, 64'd0}));
    end
    wr_en = 1'b0;
    retire_valid = 1'b0;
  endtask

  task automatic clear_stim(input bit ret_all);
    for (int k = 0; k < NCYC; k++) begin
      s_ret[k]  = ret_all;
      s_en[k]   = 1'b0;
      s_addr[k] = TOHOST;
      s_data[k] = 32'd1;
    end
  endtask

  task automatic put_store(input int k, input logic [31:0] addr, input logic [31:0] data);
    s_en[k]   = 1'b1;
    s_addr[k] = addr;
    s_data[k] = data;
  endtask

  // Issue n_run RUN cycles of stimulus (expected verdicts queued first), then reset.
  task automatic run_scenario(input int n_run);
    bit            hit;
    logic [RW-1:0] e;
    e = model(STALL_A, n_run, hit);
    if (hit) exp_qa.push_back(e);
    e = model(0, n_run, hit);
    if (hit) exp_qb.push_back(e);
    for (int k = 0; k < n_run; k++) begin
      retire_valid = s_ret[k];
      wr_en        = s_en[k];
      wr_addr      = s_addr[k];
      wr_data      = s_data[k];
      @(posedge clk); #1;
    end
    retire_valid = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);
    check("pending_a", RW'(exp_qa.size()), '0);
    check("pending_b", RW'(exp_qb.size()), '0);
    exp_qa.delete();
    exp_qb.delete();
    apply_reset($urandom_range(1, 3));
  endtask

  initial begin
    apply_reset(3);

    clear_stim(1'b1);                             // reset mid-RUN at cycle 30
    run_scenario(30);

    clear_stim(1'b1);                             // pass at cycle 20, reset while in PASS
    put_store(20, TOHOST, 32'd1);
    run_scenario(NCYC);

    clear_stim(1'b1);                             // ignored stores, then fail code 3
    put_store(5, TOHOST, 32'd4);
    put_store(8, TOHOST + 32'd4, 32'd1);
    put_store(12, TOHOST, 32'd7);
    run_scenario(NCYC);

    clear_stim(1'b1);                             // timeout
    run_scenario(NCYC);

    clear_stim(1'b1);                             // pass wins over timeout in the deadline cycle
    put_store(TO_CYC - 1, TOHOST, 32'd1);
    run_scenario(NCYC);

    clear_stim(1'b0);                             // retires stop after cycle 10
    for (int k = 0; k <= 10; k++) s_ret[k] = 1'b1;
    run_scenario(NCYC);

    for (int r = 0; r < 10; r++) begin
      int p;
      p = $urandom_range(1, 6);
      for (int k = 0; k < NCYC; k++) begin
        s_ret[k] = ($urandom_range(0, p) != 0);
        s_en[k]  = ($urandom_range(0, 11) == 0);
        case ($urandom_range(0, 2))
          0:       s_addr[k] = TOHOST;
          1:       s_addr[k] = TOHOST + 32'd4;
          default: s_addr[k] = 32'($urandom);
        endcase
        case ($urandom_range(0, 2))
          0:       s_data[k] = 32'd1;
          1:       s_data[k] = 32'($urandom) | 32'd1;
          default: s_data[k] = 32'($urandom) & ~32'd1;
        endcase
      end
      run_scenario(NCYC);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
